cr_mux_sel_arb: RTL and testbench
=================================

Name: cr_mux_sel_arb

Overview:
- Round-robin, packet-aware arbiter and output register stage that sits directly upstream of the AND-OR mux cells in the common library.
- Merges N requestor streams onto one valid/ready stream.
- Generates the one-hot grant legs that drive the mux AND terms, so exactly one leg is ever active.
- Holds the grant for a whole packet (up to and including eop) and registers the selected beat for timing closure.

Parameters:
N_REQ, 4, number of requestors (2..16)
DATA_W, 32, payload width per requestor
SRC_W, $clog2(N_REQ), width of the source index

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
req_valid  input  N_REQ  per-requestor beat valid
req_eop  input  N_REQ  per-requestor end-of-packet, qualified by req_valid
req_data  input  N_REQ*DATA_W  per-requestor payload; requestor i occupies bits [i*DATA_W +: DATA_W]
req_ready  output  N_REQ  per-requestor accept
grant  output  N_REQ  one-hot combinational grant (the mux select legs)
out_valid  output  1  registered beat valid
out_eop  output  1  registered end-of-packet
out_data  output  DATA_W  registered payload
out_src  output  SRC_W  source index of the registered beat
out_ready  input  1  downstream accept

Behaviour:
- Interface: one clock `clk`. `rst` is synchronous and active-high.
- Reset values:
  - out_valid=0, out_eop=0, out_data=0, out_src=0.
  - rr_ptr=0, state=IDLE, lock_src=0.
- Slot availability: slot_free = !out_valid | out_ready.
- req_ready[i] = slot_free & grant[i]. A requestor's beat transfers when req_valid[i] & req_ready[i].
- Grant logic:
  - IDLE: grant is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, … and wrapping mod N_REQ. grant is 0 if no requestor is valid.
  - LOCKED: grant[lock_src] = req_valid[lock_src]. All other grant bits are 0.
- grant is independent of out_ready. It shows the intended source even while the output is stalled.
- Latency: 1 cycle from transfer to out_valid.
  - On a transfer: out_data, out_eop and out_src load the granted beat, and out_valid=1.
  - If slot_free and no transfer: out_valid becomes 0.
  - Otherwise all output registers hold.
- State machine (IDLE, LOCKED) advances only on a transfer:
  - IDLE, beat with eop=0: go to LOCKED and set lock_src = granted index.
  - IDLE, beat with eop=1 (single-beat packet): stay in IDLE and set rr_ptr = idx+1 mod N_REQ.
  - LOCKED, beat with eop=1: go to IDLE and set rr_ptr = lock_src+1 mod N_REQ.
  - LOCKED, beat with eop=0: stay in LOCKED.
- Wrap-around: when idx = N_REQ-1, rr_ptr becomes 0.
- Boundary cases:
  - A stall in LOCKED (lock_src invalid) holds the lock. No other requestor is served mid-packet.
  - A lone requestor is re-granted back-to-back with no bubble.
  - Full throughput of 1 beat/cycle is sustained while out_ready=1.
  - A simultaneous downstream pop and upstream transfer is allowed; the register reloads in the same cycle.
- rst asserted mid-packet: everything returns to reset values. The partial packet is abandoned; requestors must resync.

Optional Feature:
- Macro: CR_MUX_SEL_ARB_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt (16 bits), a saturating count of cycles with out_valid & !out_ready.
  - Saturates at 16'hFFFF.
  - Cleared only by rst.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package cr_mux_sel_arb_pkg holds:
  - typedef of the state enum {IDLE, LOCKED}.
  - A function returning the next rr_ptr with wrap.
  - The stall counter width constant 16.
- One sub-module, cr_rr_pick: combinational rotate-priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot pick and encoded index.
  - Reusable by other arbiters.

Test Plan:
- rst=1 with random inputs, then rst=0 -> all outputs 0 on the first cycle after release; grant follows req_valid combinationally.
- N_REQ=4, all four sending single-beat eop=1 packets, out_ready=1 -> out_src sequence 0,1,2,3,0 and one beat per cycle.
- Req0 sends a 3-beat packet while req1 is valid throughout -> out_src 0,0,0,1; req_ready[1]=0 during the lock.
- Req2 drops valid mid-packet for 2 cycles while req3 is valid -> no req3 beat until req2's eop; the lock holds.
- out_ready=0 for 5 cycles with a beat held -> out_data stable, all req_ready=0, stall_cnt=5 (macro on).
- rst pulsed while LOCKED on src1 -> state IDLE, rr_ptr=0; the next grant goes to the lowest valid index.

Source files
------------

// File: rtl/cr_mux_sel_arb_pkg.sv
// Shared types and helpers for the cr_mux_sel_arb packet-aware round-robin arbiter.
package cr_mux_sel_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int STALL_CNT_W = 16;

    // Round-robin pointer for the requestor after idx, wrapping back to 0 after n-1.
    function automatic int next_rr_ptr(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cr_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr, wrapping.
module cr_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     pick,
    output logic [IDX_W-1:0] idx
);

    int               pos;
    logic [IDX_W-1:0] pos_idx;
    logic             found;

    always_comb begin
        pick    = '0;
        idx     = '0;
        found   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_idx = IDX_W'(pos);
            if (!found && req[pos_idx]) begin
                found         = 1'b1;
                pick[pos_idx] = 1'b1;
                idx           = pos_idx;
            end
        end
    end

endmodule

// File: rtl/cr_mux_sel_arb.sv
// Packet-aware round-robin arbiter with registered output beat and one-hot mux grant legs.
// Optional stall counter port enabled by defining CR_MUX_SEL_ARB_STALL_CNT_EN.
module cr_mux_sel_arb
    import cr_mux_sel_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    parameter int SRC_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_eop,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        grant,
    output logic                    out_valid,
    output logic                    out_eop,
    output logic [DATA_W-1:0]       out_data,
    output logic [SRC_W-1:0]        out_src,
`ifdef CR_MUX_SEL_ARB_STALL_CNT_EN
    input  logic                    out_ready,
    output logic [STALL_CNT_W-1:0]  stall_cnt
`else
    input  logic                    out_ready
`endif
);

    arb_state_t        state;
    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W-1:0]  lock_src;
    logic [SRC_W-1:0]  pick_idx;
    logic [SRC_W-1:0]  sel_idx;
    logic [N_REQ-1:0]  pick_onehot;
    logic [DATA_W-1:0] sel_data;
    logic              sel_eop;
    logic              slot_free;
    logic              transfer;

    cr_rr_pick #(
        .N     (N_REQ),
        .IDX_W (SRC_W)
    ) u_pick (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .pick (pick_onehot),
        .idx  (pick_idx)
    );

    // While a packet is in flight only the locked source may drive the mux legs.
    always_comb begin
        grant   = '0;
        sel_idx = pick_idx;
        if (state == LOCKED) begin
            sel_idx         = lock_src;
            grant[lock_src] = req_valid[lock_src];
        end else begin
            grant = pick_onehot;
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel_idx == SRC_W'(i)) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign sel_eop   = req_eop[sel_idx];
    assign slot_free = !out_valid || out_ready;
    assign req_ready = {N_REQ{slot_free}} & grant;
    assign transfer  = slot_free && (|grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_eop   <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= '0;
            lock_src  <= '0;
            state     <= IDLE;
        end else if (transfer) begin
            out_valid <= 1'b1;
            out_eop   <= sel_eop;
            out_data  <= sel_data;
            out_src   <= sel_idx;
            if (state == IDLE) begin
                if (sel_eop) begin
                    rr_ptr <= SRC_W'(next_rr_ptr(int'(pick_idx), N_REQ));
                end else begin
                    state    <= LOCKED;
                    lock_src <= pick_idx;
                end
            end else if (sel_eop) begin
                state  <= IDLE;
                rr_ptr <= SRC_W'(next_rr_ptr(int'(lock_src), N_REQ));
            end
        end else if (slot_free) begin
            out_valid <= 1'b0;
        end
    end

`ifdef CR_MUX_SEL_ARB_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cr_mux_sel_arb.sv
// Directed, table-driven bench for cr_mux_sel_arb with N_REQ=4, DATA_W=32.
module tb_cr_mux_sel_arb;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 32;
    localparam int SRC_W  = 2;
    localparam int N_VEC  = 27;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  eop;
        logic        ordy;
        logic [3:0]  exp_grant;
        logic [3:0]  exp_ready;
        logic        exp_ov;
        logic        exp_oeop;
        logic [1:0]  exp_src;
        logic [31:0] exp_data;
    } vec_t;

    logic                    clk;
    logic                    rst;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_eop;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        grant;
    logic                    out_valid;
    logic                    out_eop;
    logic [DATA_W-1:0]       out_data;
    logic [SRC_W-1:0]        out_src;
    logic                    out_ready;
`ifdef CR_MUX_SEL_ARB_STALL_CNT_EN
    logic [15:0]             stall_cnt;
`endif

    int   checks;
    int   errors;
    vec_t vecs[N_VEC];

    cr_mux_sel_arb #(
        .N_REQ  (N_REQ),
        .DATA_W (DATA_W),
        .SRC_W  (SRC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_eop   (req_eop),
        .req_data  (req_data),
        .req_ready (req_ready),
        .grant     (grant),
        .out_valid (out_valid),
        .out_eop   (out_eop),
        .out_data  (out_data),
        .out_src   (out_src),
`ifdef CR_MUX_SEL_ARB_STALL_CNT_EN
        .out_ready (out_ready),
        .stall_cnt (stall_cnt)
`else
        .out_ready (out_ready)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Payload stamped with the cycle number and requestor so every beat is unique.
    function automatic logic [31:0] beat(input int step, input int src);
        return {16'hC0DE, 8'(step), 8'(src)};
    endfunction

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] e, input logic r,
                                input logic [3:0] g, input logic [3:0] rd, input logic ov,
                                input logic oe, input logic [1:0] src, input logic [31:0] d);
        vec_t t;
        t.valid     = v;
        t.eop       = e;
        t.ordy      = r;
        t.exp_grant = g;
        t.exp_ready = rd;
        t.exp_ov    = ov;
        t.exp_oeop  = oe;
        t.exp_src   = src;
        t.exp_data  = d;
        return t;
    endfunction

    task automatic applyStimulus(input logic [3:0] v, input logic [3:0] e, input logic r,
                                 input int stamp);
        req_valid = v;
        req_eop   = e;
        out_ready = r;
        for (int i = 0; i < N_REQ; i++) begin
            req_data[i*DATA_W +: DATA_W] = beat(stamp, i);
        end
    endtask

    task automatic checkOutput(input string name, input int step, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req_valid = 4'($urandom);
        req_eop   = 4'($urandom);
        out_ready = 1'($urandom);
        req_data  = {$urandom, $urandom, $urandom, $urandom};

        // Round robin with single-beat packets, then wrap and drain.
        vecs[0]  = mk(4'hF, 4'hF, 1, 4'h1, 4'h1, 0, 0, 0, 32'h0);
        vecs[1]  = mk(4'hF, 4'hF, 1, 4'h2, 4'h2, 1, 1, 0, beat(0, 0));
        vecs[2]  = mk(4'hF, 4'hF, 1, 4'h4, 4'h4, 1, 1, 1, beat(1, 1));
        vecs[3]  = mk(4'hF, 4'hF, 1, 4'h8, 4'h8, 1, 1, 2, beat(2, 2));
        vecs[4]  = mk(4'hF, 4'hF, 1, 4'h1, 4'h1, 1, 1, 3, beat(3, 3));
        vecs[5]  = mk(4'h0, 4'h0, 1, 4'h0, 4'h0, 1, 1, 0, beat(4, 0));
        vecs[6]  = mk(4'h0, 4'h0, 1, 4'h0, 4'h0, 0, 1, 0, beat(4, 0));
        // Requestor 1 sends a 3-beat packet while requestor 2 waits.
        vecs[7]  = mk(4'h6, 4'h4, 1, 4'h2, 4'h2, 0, 1, 0, beat(4, 0));
        vecs[8]  = mk(4'h6, 4'h4, 1, 4'h2, 4'h2, 1, 0, 1, beat(7, 1));
        vecs[9]  = mk(4'h6, 4'h6, 1, 4'h2, 4'h2, 1, 0, 1, beat(8, 1));
        vecs[10] = mk(4'h4, 4'h4, 1, 4'h4, 4'h4, 1, 1, 1, beat(9, 1));
        vecs[11] = mk(4'h0, 4'h0, 1, 4'h0, 4'h0, 1, 1, 2, beat(10, 2));
        // Requestor 2 drops valid mid-packet; requestor 3 must wait for the eop.
        vecs[12] = mk(4'h4, 4'h0, 1, 4'h4, 4'h4, 0, 1, 2, beat(10, 2));
        vecs[13] = mk(4'h8, 4'h8, 1, 4'h0, 4'h0, 1, 0, 2, beat(12, 2));
        vecs[14] = mk(4'h8, 4'h8, 1, 4'h0, 4'h0, 0, 0, 2, beat(12, 2));
        vecs[15] = mk(4'hC, 4'hC, 1, 4'h4, 4'h4, 0, 0, 2, beat(12, 2));
        vecs[16] = mk(4'h8, 4'h8, 1, 4'h8, 4'h8, 1, 1, 2, beat(15, 2));
        // Lone requestor 0 re-granted back-to-back, then a 5-cycle downstream stall.
        vecs[17] = mk(4'h1, 4'h1, 1, 4'h1, 4'h1, 1, 1, 3, beat(16, 3));
        vecs[18] = mk(4'h1, 4'h1, 1, 4'h1, 4'h1, 1, 1, 0, beat(17, 0));
        for (int i = 19; i < 24; i++) begin
            vecs[i] = mk(4'h1, 4'h1, 0, 4'h1, 4'h0, 1, 1, 0, beat(18, 0));
        end
        vecs[24] = mk(4'h1, 4'h1, 1, 4'h1, 4'h1, 1, 1, 0, beat(18, 0));
        vecs[25] = mk(4'h0, 4'h0, 1, 4'h0, 4'h0, 1, 1, 0, beat(24, 0));
        vecs[26] = mk(4'h0, 4'h0, 1, 4'h0, 4'h0, 0, 1, 0, beat(24, 0));

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int s = 0; s < N_VEC; s++) begin
            applyStimulus(vecs[s].valid, vecs[s].eop, vecs[s].ordy, s);
            @(negedge clk);
            checkOutput("grant", s, 32'(grant), 32'(vecs[s].exp_grant));
            checkOutput("req_ready", s, 32'(req_ready), 32'(vecs[s].exp_ready));
            checkOutput("out_valid", s, 32'(out_valid), 32'(vecs[s].exp_ov));
            checkOutput("out_eop", s, 32'(out_eop), 32'(vecs[s].exp_oeop));
            checkOutput("out_src", s, 32'(out_src), 32'(vecs[s].exp_src));
            checkOutput("out_data", s, out_data, vecs[s].exp_data);
            @(posedge clk);
            #1;
        end

`ifdef CR_MUX_SEL_ARB_STALL_CNT_EN
        checkOutput("stall_cnt", N_VEC, 32'(stall_cnt), 32'd5);
`endif

        // Lock onto requestor 1, then reset mid-packet.
        applyStimulus(4'h2, 4'h0, 1, 40);
        @(negedge clk);
        checkOutput("lock_grant", 40, 32'(grant), 32'h2);
        @(posedge clk);
        #1;
        applyStimulus(4'h3, 4'h0, 1, 41);
        @(negedge clk);
        checkOutput("locked_grant", 41, 32'(grant), 32'h2);
        checkOutput("locked_ready", 41, 32'(req_ready), 32'h2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(4'h3, 4'h0, 1, 42);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(4'h3, 4'h0, 1, 43);
        @(negedge clk);
        checkOutput("rst_grant", 43, 32'(grant), 32'h1);
        checkOutput("rst_out_valid", 43, 32'(out_valid), 32'h0);
        checkOutput("rst_out_src", 43, 32'(out_src), 32'h0);
        checkOutput("rst_out_eop", 43, 32'(out_eop), 32'h0);
        checkOutput("rst_out_data", 43, out_data, 32'h0);
`ifdef CR_MUX_SEL_ARB_STALL_CNT_EN
        checkOutput("rst_stall_cnt", 43, 32'(stall_cnt), 32'h0);
`endif
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
